// File: rtl/sbox_table_builder.sv
// rtl/sbox_table_builder.sv - collects candidate bytes into a bijective S-box and serves lookups
//
// Purpose:
//   Builds a 2**MIX_WIDTH-entry permutation table from a stream of candidate
//   symbols (duplicates rejected). If the candidate budget runs out first,
//   the missing symbols are appended in ascending order. Once complete, the
//   table answers registered lookups with a latency of one cycle.
//
// Optional feature macro: SBOX_INVERSE_EN
//   Adds an inverse table (inv[value] = index), written alongside the forward
//   table, plus the inv_en/inv_addr/inv_rd_valid/inv_data lookup port.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   start                   pulse, begins a build from IDLE or READY
//   in_valid, V_in          candidate symbol stream
//   collecting, ready       state indicators (COLLECT, READY)
//   count, dup_count        entries written, saturating duplicate count
//   fill_used               table was completed by the deterministic fill
//   lut_en, lut_addr        forward lookup request (honoured in READY)
//   lut_rd_valid, lut_data  forward lookup result, one cycle later

module sbox_table_builder #(
    parameter int MIX_WIDTH      = 8,
    parameter int MAX_CANDIDATES = 4096,
    parameter int DUP_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [MIX_WIDTH-1:0] V_in,
    output logic                 collecting,
    output logic                 ready,
    output logic [MIX_WIDTH:0]   count,
    output logic [DUP_WIDTH-1:0] dup_count,
    output logic                 fill_used,
    input  logic                 lut_en,
    input  logic [MIX_WIDTH-1:0] lut_addr,
    output logic                 lut_rd_valid,
    output logic [MIX_WIDTH-1:0] lut_data
`ifdef SBOX_INVERSE_EN
    ,
    input  logic                 inv_en,
    input  logic [MIX_WIDTH-1:0] inv_addr,
    output logic                 inv_rd_valid,
    output logic [MIX_WIDTH-1:0] inv_data
`endif
);

    localparam int N  = 1 << MIX_WIDTH;
    localparam int CW = $clog2(MAX_CANDIDATES + 1);
    localparam logic [MIX_WIDTH:0] N_CNT    = (MIX_WIDTH+1)'(N);
    localparam logic [CW-1:0]      CAND_MAX = CW'(MAX_CANDIDATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_FILL,
        S_READY
    } state_t;

    state_t                 state_q, state_d;
    logic [N-1:0]           used_q, used_d;
    logic [MIX_WIDTH:0]     count_q, count_d;
    logic [CW-1:0]          cand_q, cand_d;
    logic [DUP_WIDTH-1:0]   dup_q, dup_d;
    logic [MIX_WIDTH-1:0]   fill_ptr_q, fill_ptr_d;
    logic                   fill_used_q, fill_used_d;
    logic                   lut_rd_valid_q, lut_rd_valid_d;
    logic [MIX_WIDTH-1:0]   lut_data_q, lut_data_d;

    logic                   wr_en;
    logic [MIX_WIDTH-1:0]   wr_addr;
    logic [MIX_WIDTH-1:0]   wr_data;

    logic [MIX_WIDTH-1:0]   table_mem [N];

    always_comb begin
        state_d     = state_q;
        used_d      = used_q;
        count_d     = count_q;
        cand_d      = cand_q;
        dup_d       = dup_q;
        fill_ptr_d  = fill_ptr_q;
        fill_used_d = fill_used_q;
        wr_en       = 1'b0;
        wr_addr     = count_q[MIX_WIDTH-1:0];
        wr_data     = V_in;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                used_d      = '0;
                count_d     = '0;
                cand_d      = '0;
                dup_d       = '0;
                fill_ptr_d  = '0;
                fill_used_d = 1'b0;
                state_d     = S_COLLECT;
            end
            S_COLLECT: begin
                if (in_valid) begin
                    cand_d = cand_q + CW'(1);
                    if (!used_q[V_in]) begin
                        wr_en          = 1'b1;
                        used_d[V_in]   = 1'b1;
                        count_d        = count_q + (MIX_WIDTH+1)'(1);
                    end else if (dup_q != '1) begin
                        dup_d = dup_q + DUP_WIDTH'(1);
                    end
                end
                // Completion wins when the last unique symbol is also the
                // final permitted candidate.
                if (count_d == N_CNT) begin
                    state_d = S_READY;
                end else if (cand_d == CAND_MAX) begin
                    state_d     = S_FILL;
                    fill_used_d = 1'b1;
                end
            end
            S_FILL: begin
                // Sweep every symbol once; unused ones are appended in order.
                wr_data    = fill_ptr_q;
                fill_ptr_d = fill_ptr_q + MIX_WIDTH'(1);
                if (!used_q[fill_ptr_q]) begin
                    wr_en              = 1'b1;
                    used_d[fill_ptr_q] = 1'b1;
                    count_d            = count_q + (MIX_WIDTH+1)'(1);
                end
                if (count_d == N_CNT) state_d = S_READY;
            end
            S_READY: begin
                if (start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Writes happen only outside READY and reads only in READY, so the
    // registered read never races a write.
    always_comb begin
        lut_rd_valid_d = (state_q == S_READY) && lut_en;
        lut_data_d     = lut_data_q;
        if (lut_rd_valid_d) lut_data_d = table_mem[lut_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            used_q         <= '0;
            count_q        <= '0;
            cand_q         <= '0;
            dup_q          <= '0;
            fill_ptr_q     <= '0;
            fill_used_q    <= 1'b0;
            lut_rd_valid_q <= 1'b0;
            lut_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            used_q         <= used_d;
            count_q        <= count_d;
            cand_q         <= cand_d;
            dup_q          <= dup_d;
            fill_ptr_q     <= fill_ptr_d;
            fill_used_q    <= fill_used_d;
            lut_rd_valid_q <= lut_rd_valid_d;
            lut_data_q     <= lut_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) table_mem[wr_addr] <= wr_data;
    end

`ifdef SBOX_INVERSE_EN
    logic [MIX_WIDTH-1:0] inv_mem [N];
    logic                 inv_rd_valid_q, inv_rd_valid_d;
    logic [MIX_WIDTH-1:0] inv_data_q, inv_data_d;

    always_comb begin
        inv_rd_valid_d = (state_q == S_READY) && inv_en;
        inv_data_d     = inv_data_q;
        if (inv_rd_valid_d) inv_data_d = inv_mem[inv_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inv_rd_valid_q <= 1'b0;
            inv_data_q     <= '0;
        end else begin
            inv_rd_valid_q <= inv_rd_valid_d;
            inv_data_q     <= inv_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) inv_mem[wr_data] <= wr_addr;
    end

    assign inv_rd_valid = inv_rd_valid_q;
    assign inv_data     = inv_data_q;
`endif

    assign collecting   = (state_q == S_COLLECT);
    assign ready        = (state_q == S_READY);
    assign count        = count_q;
    assign dup_count    = dup_q;
    assign fill_used    = fill_used_q;
    assign lut_rd_valid = lut_rd_valid_q;
    assign lut_data     = lut_data_q;

endmodule

// File: tb/tb_sbox_table_builder.sv
// tb/tb_sbox_table_builder.sv - scoreboard bench for sbox_table_builder
`timescale 1ns/1ps
module tb_sbox_table_builder;
    localparam int MW   = 8;
    localparam int N    = 256;
    localparam int MAXC = 300;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [MW-1:0] V_in = '0;
    logic          collecting, ready, fill_used, lut_rd_valid;
    logic [MW:0]   count;
    logic [DW-1:0] dup_count;
    logic          lut_en = 1'b0;
    logic [MW-1:0] lut_addr = '0;
    logic [MW-1:0] lut_data;
`ifdef SBOX_INVERSE_EN
    logic          inv_en = 1'b0;
    logic [MW-1:0] inv_addr = '0;
    logic          inv_rd_valid;
    logic [MW-1:0] inv_data;
`endif

    sbox_table_builder #(.MIX_WIDTH(MW), .MAX_CANDIDATES(MAXC), .DUP_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .V_in(V_in),
        .collecting(collecting), .ready(ready), .count(count), .dup_count(dup_count),
        .fill_used(fill_used), .lut_en(lut_en), .lut_addr(lut_addr),
        .lut_rd_valid(lut_rd_valid), .lut_data(lut_data)
`ifdef SBOX_INVERSE_EN
        , .inv_en(inv_en), .inv_addr(inv_addr), .inv_rd_valid(inv_rd_valid), .inv_data(inv_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [MW-1:0] data; int cyc; } exp_t;
    exp_t fq[$];
    exp_t iq[$];

    // Reference model: phase 0 idle, 1 collecting, 2 ready, 3 fill pending.
    int            m_phase = 0;
    logic [MW-1:0] m_tab[$];
    bit            m_seen[N];
    int            m_cand, m_dup;
    bit            m_fill;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_begin();
        m_tab.delete();
        foreach (m_seen[i]) m_seen[i] = 1'b0;
        m_cand = 0; m_dup = 0; m_fill = 1'b0; m_phase = 1;
    endfunction

    function automatic void m_feed(input logic [MW-1:0] b);
        if (m_phase != 1) return;
        m_cand++;
        if (!m_seen[b]) begin
            m_seen[b] = 1'b1;
            m_tab.push_back(b);
        end else if (m_dup < (1 << DW) - 1) begin
            m_dup++;
        end
        if (m_tab.size() == N) begin
            m_phase = 2;
        end else if (m_cand == MAXC) begin
            m_fill = 1'b1;
            for (int v = 0; v < N; v++)
                if (!m_seen[v]) begin m_seen[v] = 1'b1; m_tab.push_back(MW'(v)); end
            m_phase = 3;
        end
    endfunction

    function automatic int m_inv(input int value);
        for (int i = 0; i < m_tab.size(); i++) if (int'(m_tab[i]) == value) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (lut_rd_valid) begin
            if (fq.size() == 0) begin
                checks++; failures++;
                $display("FAIL lut_unexpected_valid: got valid data=%0d expected no valid", lut_data);
            end else begin
                e = fq.pop_front();
                check("lut_data", lut_data, e.data);
                check("lut_latency", cyc, e.cyc);
            end
        end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
            e = fq.pop_front();
            check("lut_missing_valid", 0, 1);
        end
`ifdef SBOX_INVERSE_EN
        if (inv_rd_valid) begin
            if (iq.size() == 0) begin
                checks++; failures++;
                $display("FAIL inv_unexpected_valid: got valid data=%0d expected no valid", inv_data);
            end else begin
                e = iq.pop_front();
                check("inv_data", inv_data, e.data);
                check("inv_latency", cyc, e.cyc);
            end
        end else if (iq.size() > 0 && iq[0].cyc <= cyc) begin
            e = iq.pop_front();
            check("inv_missing_valid", 0, 1);
        end
`endif
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic lookup(input logic [MW-1:0] a);
        exp_t e;
        lut_en = 1'b1; lut_addr = a;
        if (m_phase == 2) begin e.data = m_tab[a]; e.cyc = cyc + 1; fq.push_back(e); end
        tick();
        lut_en = 1'b0;
    endtask

    task automatic sweep();
        for (int a = 0; a < N; a++) lookup(MW'(a));
        for (int k = 0; k < 40; k++) lookup(MW'($urandom_range(0, N - 1)));
`ifdef SBOX_INVERSE_EN
        for (int a = 0; a < N; a++) begin
            exp_t e;
            inv_en = 1'b1; inv_addr = MW'(a);
            e.data = MW'(m_inv(a)); e.cyc = cyc + 1; iq.push_back(e);
            tick();
        end
        inv_en = 1'b0;
`endif
        tick(); tick();
        check("lut_queue_drained", fq.size(), 0);
    endtask

    task automatic wait_collecting();
        int k = 0;
        while (!collecting && k < 5) begin tick(); k++; end
        check("collecting_after_start", collecting, 1);
        m_begin();
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
        wait_collecting();
    endtask

    task automatic feed(input logic [MW-1:0] b);
        in_valid = 1'b1; V_in = b; tick(); in_valid = 1'b0;
        m_feed(b);
    endtask

    task automatic finish_build();
        if (m_phase == 3) begin
            int k = 0;
            while (!ready && k < N + 4) begin
                in_valid = 1'($urandom); V_in = MW'($urandom); tick(); k++;
            end
            in_valid = 1'b0;
            check("fill_reaches_ready", ready, 1);
            check("fill_cycles_le_N", int'(k <= N), 1);
            m_phase = 2;
        end else begin
            check("ready_after_last_sample", ready, 1);
        end
        check("count_done", count, N);
        check("dup_count", dup_count, m_dup);
        check("fill_used", fill_used, m_fill);
        check("collecting_low_in_ready", collecting, 0);
    endtask

    task automatic feed_perm(input int upto);
        int p[N];
        for (int i = 0; i < N; i++) p[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j = $urandom_range(0, i); int t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int i = 0; i < upto; i++) feed(MW'(p[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        check("rst_collecting", collecting, 0);
        check("rst_ready", ready, 0);
        check("rst_count", count, 0);
        check("rst_dup", dup_count, 0);
        check("rst_fill_used", fill_used, 0);
        check("rst_lut_valid", lut_rd_valid, 0);
        check("rst_lut_data", lut_data, 0);
        reset_n = 1'b1; tick();

        // Lookup and in_valid in IDLE are ignored.
        lookup(8'h12); feed(8'h44); tick();
        check("idle_lut_data_hold", lut_data, 0);
        check("idle_count", count, 0);

        // Duplicate rejection, then ascending completion.
        do_start();
        feed(8'hA5); feed(8'hA5); feed(8'h3C);
        check("dup_test_count", count, 2);
        check("dup_test_dup", dup_count, 1);
        for (int v = 0; v < N; v++) feed(MW'(v));
        finish_build();
        sweep();

        // in_valid in READY ignored.
        for (int k = 0; k < 5; k++) feed(MW'($urandom));
        check("ready_ignore_count", count, N);
        check("ready_ignore_dup", dup_count, m_dup);

        // Lookup coinciding with start still returns; ready falls next cycle.
        begin
            exp_t e;
            lut_en = 1'b1; lut_addr = 8'h05; start = 1'b1;
            e.data = m_tab[8'h05]; e.cyc = cyc + 1; fq.push_back(e);
            tick();
            lut_en = 1'b0; start = 1'b0; m_phase = 0;
            check("ready_falls_after_start", ready, 0);
            wait_collecting();
        end
        check("clear_count", count, 0);
        check("clear_dup", dup_count, 0);

        // Forced fill: one symbol repeated up to the candidate limit.
        for (int k = 0; k < MAXC; k++) feed(8'h07);
        check("fill_entered_not_collecting", collecting, 0);
        finish_build();
        sweep();

        // Completion on exactly the last permitted candidate.
        do_start();
        for (int k = 0; k < MAXC - N + 1; k++) feed(8'h00);
        for (int v = 1; v < N; v++) feed(MW'(v));
        finish_build();
        sweep();

        // Random candidate stream.
        do_start();
        while (m_phase == 1) feed(MW'($urandom_range(0, N - 1)));
        finish_build();
        sweep();

        // Reset mid-collect; start during COLLECT ignored.
        do_start();
        feed_perm(100);
        start = 1'b1; tick(); start = 1'b0;
        check("start_in_collect_ignored", collecting, 1);
        check("start_in_collect_count", count, 100);
        @(posedge clk); #2; reset_n = 1'b0; #1;
        check("async_rst_collecting", collecting, 0);
        check("async_rst_count", count, 0);
        check("async_rst_lut_data", lut_data, 0);
        m_phase = 0;
        tick(); reset_n = 1'b1; tick();
        do_start();
        feed_perm(N);
        finish_build();
        sweep();

        tick(); tick();
        check("scoreboard_empty", fq.size() + iq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
